gauss_conv_mac: RTL and testbench
=================================

Name: gauss_conv_mac

Overview:
Downstream consumer of the Gaussian kernel generator. It latches the generated kernel (8-bit weights, unnormalised) and its weight sum. For each pixel window offered upstream it performs a sequential multiply-accumulate, one tap per cycle. It then divides by the weight sum with a bit-serial restoring divider and emits one blurred 8-bit pixel on a valid/ready handshake toward the corner detector.

Parameters:
MAX_KERNEL, 7, max kernel/window edge length; window and kernel arrays are MAX_KERNEL x MAX_KERNEL.
ACC_W, 24, accumulator and divider width; must hold MAX_KERNEL^2 * 255 * 255.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
kernel_valid  in  1  single-cycle pulse (generator done); load kernel shadow registers
kernel  in  MAX_KERNEL*MAX_KERNEL*8  packed [x][y][7:0] weights
kernel_sum  in  32  sum of weights
kernel_size  in  $clog2(MAX_KERNEL)  active edge length k
win_valid  in  1  window offered
win_ready  out  1  block can accept window
window  in  MAX_KERNEL*MAX_KERNEL*8  packed [x][y][7:0] pixels
pix_out  out  8  normalised pixel
pix_valid  out  1  pix_out valid
pix_ready  in  1  consumer accepts pix_out
busy  out  1  state != IDLE
err_div0  out  1  last result used kernel_sum==0; sticky until next window accept

Behaviour:
- Reset (asynchronous, any state including mid-operation): state IDLE; accumulator, indices, shadow/active kernel, sum, k, window regs cleared. Outputs: win_ready=1, pix_valid=0, pix_out=0, busy=0, err_div0=0.
- Kernel shadow: kernel_valid loads kernel, kernel_sum and kernel_size into the shadow in any state. Shadow copies into the active set only on a window accept, so an in-flight pixel never sees a partial kernel update. kernel_valid on the same edge as a window accept: the accept uses the OLD shadow; the new values land in the shadow.
- FSM states: IDLE, MAC, DIV, OUT.
- IDLE:
  - win_ready=1.
  - On win_valid&&win_ready: latch window, copy shadow to active, clear acc, x=y=0, clear err_div0.
  - Next state: MAC, or DIV if k==0.
- MAC:
  - win_ready=0.
  - Each cycle acc += window[x][y]*kernel[x][y] (8x8 unsigned product, zero-extended to ACC_W).
  - x increments 0..k-1, then wraps to 0 and y increments.
  - After tap (k-1,k-1) -> DIV.
  - Exactly k*k cycles. Entries with x>=k or y>=k are never read.
- DIV:
  - Restoring divide acc / kernel_sum[ACC_W-1:0], one quotient bit per cycle, MSB first, exactly ACC_W cycles. Result is floor.
  - kernel_sum==0: divider bypassed but still takes ACC_W cycles; result 0; err_div0 set.
  - kernel_sum bits above ACC_W are nonzero: quotient treated as 0.
  - Quotient > 255 saturates to 255.
  - Then -> OUT.
- OUT:
  - pix_valid=1; pix_out holds stable while pix_ready=0.
  - On pix_ready: -> IDLE, pix_valid drops next cycle.
  - No window is accepted in the same cycle as the output handshake; earliest accept is the following cycle.
- Latency: window accept edge E0 -> pix_valid high after edge E0 + k*k + ACC_W. Example: k=3, ACC_W=24 gives 33 cycles.
- Throughput: one pixel per k*k+ACC_W+2 cycles minimum.

Test Plan:
- Uniform 3x3 case:
  - Stimulus: kernel all 100, sum 900, k=3, window all 50.
  - Response: pix_out=50, pix_valid exactly 33 cycles after accept, err_div0=0.
- Delta kernel:
  - Stimulus: k=5, kernel[2][2]=100, others 0, sum 100, window[2][2]=200, others 7.
  - Response: pix_out=200 after 49 cycles.
- Saturation and divide-by-zero:
  - Stimulus A: k=3, kernel all 100, sum 100, window all 255.
  - Response A: pix_out=255.
  - Stimulus B: repeat with sum 0.
  - Response B: pix_out=0, err_div0=1; err_div0 clears on the next accept.
- Backpressure:
  - Stimulus: pix_ready low 10 cycles in OUT; win_valid held high throughout.
  - Response: pix_out stable, win_ready=0; new window accepted the cycle after the pix handshake.
- Kernel update race:
  - Stimulus: kernel_valid (new kernel all 1, sum 9) pulsed mid-MAC and again on the accept edge.
  - Response: current pixel uses old kernel; next pixel uses new kernel; k=1 case gives latency 25.
- Reset mid-operation:
  - Stimulus: assert n_rst low during DIV.
  - Response: immediate IDLE, pix_valid=0, busy=0, win_ready=1; shadow cleared, so the next pixel gives err_div0=1 until kernel_valid is pulsed again.

Source files
------------

// File: rtl/gauss_conv_mac.sv
// Sequential Gaussian blur MAC: one kernel tap per cycle, then a bit-serial
// restoring divide by the kernel weight sum, one saturated pixel per window.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a window; win_ready high
// MAC   | accumulating window[x][y]*kernel[x][y], one tap per cycle
// DIV   | restoring divide acc / kernel_sum, one quotient bit per cycle
// OUT   | pix_out presented, waiting for pix_ready
module gauss_conv_mac #(
    parameter int MAX_KERNEL = 7,
    parameter int ACC_W      = 24,
    localparam int KW        = $clog2(MAX_KERNEL)
) (
    input  logic                                         clk,
    input  logic                                         n_rst,
    input  logic                                         kernel_valid,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   kernel,
    input  logic [31:0]                                  kernel_sum,
    input  logic [KW-1:0]                                kernel_size,
    input  logic                                         win_valid,
    output logic                                         win_ready,
    input  logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0]   window,
    output logic [7:0]                                   pix_out,
    output logic                                         pix_valid,
    input  logic                                         pix_ready,
    output logic                                         busy,
    output logic                                         err_div0
);
    localparam int CNT_W = $clog2(ACC_W);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DIV, S_OUT} state_t;

    state_t                                   r_state;
    logic [MAX_KERNEL-1:0][MAX_KERNEL-1:0][7:0] r_sh_kern, r_kern, r_win;
    logic [31:0]                              r_sh_sum, r_sum;
    logic [KW-1:0]                            r_sh_k, r_k, r_x, r_y;
    logic [ACC_W-1:0]                         r_acc, r_rem;
    logic [CNT_W-1:0]                         r_cnt;
    logic [7:0]                               r_pix;
    logic                                     r_pix_valid, r_win_ready, r_busy, r_err;

    logic [KW-1:0]    w_k_m1;
    logic [15:0]      w_prod;
    logic [ACC_W:0]   w_rem_sh, w_div, w_rem_nx;
    logic             w_ge, w_div0, w_ovr;
    logic [ACC_W-1:0] w_quo_nx;
    logic [7:0]       w_pix_sat;

    assign w_k_m1 = r_k - KW'(1);
    assign w_prod = r_win[r_x][r_y] * r_kern[r_x][r_y];

    // The quotient shifts into the accumulator as the dividend shifts out of it.
    assign w_rem_sh  = {r_rem, r_acc[ACC_W-1]};
    assign w_div     = {1'b0, r_sum[ACC_W-1:0]};
    assign w_ge      = (w_rem_sh >= w_div);
    assign w_rem_nx  = w_ge ? (w_rem_sh - w_div) : w_rem_sh;
    assign w_quo_nx  = {r_acc[ACC_W-2:0], w_ge};
    assign w_div0    = (r_sum == 32'd0);
    assign w_ovr     = ((r_sum >> ACC_W) != 32'd0);
    assign w_pix_sat = (w_quo_nx > ACC_W'(255)) ? 8'd255 : w_quo_nx[7:0];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= S_IDLE;
            r_sh_kern   <= '0;
            r_kern      <= '0;
            r_win       <= '0;
            r_sh_sum    <= '0;
            r_sum       <= '0;
            r_sh_k      <= '0;
            r_k         <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_acc       <= '0;
            r_rem       <= '0;
            r_cnt       <= '0;
            r_pix       <= '0;
            r_pix_valid <= 1'b0;
            r_win_ready <= 1'b1;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // An accept on this edge reads the shadow before this update lands.
            if (kernel_valid) begin
                r_sh_kern <= kernel;
                r_sh_sum  <= kernel_sum;
                r_sh_k    <= kernel_size;
            end
            case (r_state)
                S_IDLE: begin
                    if (win_valid) begin
                        r_win       <= window;
                        r_kern      <= r_sh_kern;
                        r_sum       <= r_sh_sum;
                        r_k         <= r_sh_k;
                        r_acc       <= '0;
                        r_rem       <= '0;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_cnt       <= CNT_W'(ACC_W - 1);
                        r_err       <= 1'b0;
                        r_win_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_state     <= (r_sh_k == '0) ? S_DIV : S_MAC;
                    end
                end
                S_MAC: begin
                    r_acc <= r_acc + ACC_W'(w_prod);
                    if (r_x == w_k_m1) begin
                        r_x <= '0;
                        if (r_y == w_k_m1) r_state <= S_DIV;
                        else               r_y     <= r_y + KW'(1);
                    end else begin
                        r_x <= r_x + KW'(1);
                    end
                end
                S_DIV: begin
                    if (!w_div0 && !w_ovr) begin
                        r_acc <= w_quo_nx;
                        r_rem <= w_rem_nx[ACC_W-1:0];
                    end
                    if (r_cnt == '0) begin
                        r_state     <= S_OUT;
                        r_pix_valid <= 1'b1;
                        r_err       <= w_div0;
                        r_pix       <= (w_div0 || w_ovr) ? 8'd0 : w_pix_sat;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                S_OUT: begin
                    if (pix_ready) begin
                        r_state     <= S_IDLE;
                        r_pix_valid <= 1'b0;
                        r_win_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign win_ready = r_win_ready;
    assign pix_out   = r_pix;
    assign pix_valid = r_pix_valid;
    assign busy      = r_busy;
    assign err_div0  = r_err;
endmodule

// File: tb/tb_gauss_conv_mac.sv
// Self-checking bench for gauss_conv_mac: directed scenarios plus randomized
// kernels/windows compared against a plain-arithmetic blur reference.
module tb_gauss_conv_mac;
    localparam int MK = 7;
    localparam int AW = 24;
    typedef logic [MK-1:0][MK-1:0][7:0] arr_t;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        kernel_valid = 1'b0;
    arr_t        kernel = '0;
    logic [31:0] kernel_sum = '0;
    logic [2:0]  kernel_size = '0;
    logic        win_valid = 1'b0;
    logic        win_ready;
    arr_t        window = '0;
    logic [7:0]  pix_out;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic        busy;
    logic        err_div0;

    gauss_conv_mac #(.MAX_KERNEL(MK), .ACC_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .kernel_valid(kernel_valid), .kernel(kernel),
        .kernel_sum(kernel_sum), .kernel_size(kernel_size), .win_valid(win_valid),
        .win_ready(win_ready), .window(window), .pix_out(pix_out),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .busy(busy), .err_div0(err_div0)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Model of the kernel the block should be holding.
    arr_t        sh_kern = '0, act_kern = '0;
    logic [31:0] sh_sum = '0, act_sum = '0;
    int          sh_k = 0, act_k = 0;
    int          acc_cyc = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic arr_t fill(input int v);
        arr_t a;
        for (int x = 0; x < MK; x++)
            for (int y = 0; y < MK; y++)
                a[x][y] = v[7:0];
        return a;
    endfunction

    function automatic arr_t rnd_arr(input int maxv);
        arr_t a;
        for (int x = 0; x < MK; x++)
            for (int y = 0; y < MK; y++)
                a[x][y] = 8'($urandom_range(0, maxv));
        return a;
    endfunction

    function automatic int wsum(input arr_t kr, input int k);
        int s = 0;
        for (int x = 0; x < k; x++)
            for (int y = 0; y < k; y++)
                s += int'(kr[x][y]);
        return s;
    endfunction

    // Blurred pixel: floor(sum(w*k) / sum), saturated; zero sum flags an error.
    function automatic void ref_pix(input arr_t kr, input logic [31:0] s, input int k,
                                    input arr_t w, output int pix, output bit err);
        longint acc;
        acc = 0;
        err = 1'b0;
        for (int x = 0; x < k; x++)
            for (int y = 0; y < k; y++)
                acc += longint'(w[x][y]) * longint'(kr[x][y]);
        if (s == 32'd0) begin
            pix = 0;
            err = 1'b1;
        end else if (s >= 32'h0100_0000) begin
            pix = 0;
        end else begin
            acc = acc / longint'(s);
            pix = (acc > 255) ? 255 : int'(acc);
        end
    endfunction

    task automatic load_kernel(input arr_t kr, input logic [31:0] s, input int k);
        kernel       = kr;
        kernel_sum   = s;
        kernel_size  = 3'(k);
        kernel_valid = 1'b1;
        tick();
        kernel_valid = 1'b0;
        sh_kern = kr;
        sh_sum  = s;
        sh_k    = k;
    endtask

    task automatic accept_window(input arr_t w, input bit kv, input arr_t kr,
                                 input logic [31:0] s, input int k);
        int guard = 0;
        window    = w;
        win_valid = 1'b1;
        if (kv) begin
            kernel       = kr;
            kernel_sum   = s;
            kernel_size  = 3'(k);
            kernel_valid = 1'b1;
        end
        while (!win_ready && guard < 300) begin
            tick();
            guard++;
        end
        chk("accept_wait", guard < 300, 1);
        tick();
        win_valid    = 1'b0;
        kernel_valid = 1'b0;
        acc_cyc  = cyc;
        act_kern = sh_kern;
        act_sum  = sh_sum;
        act_k    = sh_k;
        if (kv) begin
            sh_kern = kr;
            sh_sum  = s;
            sh_k    = k;
        end
        chk("busy_after_accept", busy, 1);
        chk("err_clear_on_accept", err_div0, 0);
    endtask

    task automatic wait_result(input string tag, input arr_t w, input int bp);
        int  exp_pix;
        bit  exp_err;
        int  guard = 0;
        logic [7:0] held;
        ref_pix(act_kern, act_sum, act_k, w, exp_pix, exp_err);
        while (!pix_valid && guard < 300) begin
            tick();
            guard++;
        end
        chk({tag, "_valid_seen"}, pix_valid, 1);
        chk({tag, "_latency"}, cyc - acc_cyc, act_k * act_k + AW);
        chk({tag, "_pix"}, pix_out, exp_pix);
        chk({tag, "_err"}, err_div0, exp_err);
        held = pix_out;
        for (int i = 0; i < bp; i++) begin
            tick();
            chk({tag, "_hold_valid"}, pix_valid, 1);
            chk({tag, "_hold_pix"}, pix_out, held);
            chk({tag, "_hold_noready"}, win_ready, 0);
        end
        pix_ready = 1'b1;
        tick();
        pix_ready = 1'b0;
        chk({tag, "_valid_drop"}, pix_valid, 0);
        chk({tag, "_idle_ready"}, win_ready, 1);
        chk({tag, "_idle_busy"}, busy, 0);
    endtask

    arr_t w1, w2, kr;
    logic [31:0] s;
    int k;

    initial begin
        #12;
        chk("rst_win_ready", win_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_pix_out", pix_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_div0, 0);
        @(negedge clk);
        n_rst = 1'b1;
        tick();

        // Uniform 3x3
        load_kernel(fill(100), 900, 3);
        accept_window(fill(50), 0, '0, 0, 0);
        wait_result("uniform", fill(50), 0);

        // Delta 5x5
        kr = '0; kr[2][2] = 8'd100;
        w1 = fill(7); w1[2][2] = 8'd200;
        load_kernel(kr, 100, 5);
        accept_window(w1, 0, '0, 0, 0);
        wait_result("delta", w1, 0);

        // Saturation, then divide by zero
        load_kernel(fill(100), 100, 3);
        accept_window(fill(255), 0, '0, 0, 0);
        wait_result("sat", fill(255), 0);
        load_kernel(fill(100), 0, 3);
        accept_window(fill(255), 0, '0, 0, 0);
        wait_result("div0", fill(255), 0);

        // Backpressure with win_valid held high
        load_kernel(rnd_arr(255), 0, 4);
        load_kernel(sh_kern, wsum(sh_kern, 4), 4);
        w1 = rnd_arr(255);
        w2 = rnd_arr(255);
        accept_window(w1, 0, '0, 0, 0);
        window    = w2;
        win_valid = 1'b1;
        wait_result("bp", w1, 10);
        tick();
        win_valid = 1'b0;
        acc_cyc  = cyc;
        act_kern = sh_kern; act_sum = sh_sum; act_k = sh_k;
        chk("bp_next_accept", busy, 1);
        wait_result("bp2", w2, 0);

        // Kernel update race
        load_kernel(fill(100), 900, 3);
        w1 = rnd_arr(255);
        accept_window(w1, 0, '0, 0, 0);
        tick(); tick(); tick();
        load_kernel(fill(1), 9, 3);
        wait_result("race_old", w1, 0);
        w1 = rnd_arr(255);
        accept_window(w1, 1, fill(1), 1, 1);
        wait_result("race_mid", w1, 0);
        w1 = rnd_arr(255);
        accept_window(w1, 0, '0, 0, 0);
        wait_result("race_k1", w1, 0);

        // Reset during DIV
        load_kernel(fill(10), 90, 3);
        accept_window(fill(20), 0, '0, 0, 0);
        for (int i = 0; i < 12; i++) tick();
        n_rst = 1'b0;
        #2;
        chk("midrst_pix_valid", pix_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_win_ready", win_ready, 1);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        sh_kern = '0; sh_sum = 0; sh_k = 0;
        accept_window(fill(99), 0, '0, 0, 0);
        wait_result("post_rst", fill(99), 0);
        load_kernel(fill(3), 27, 3);
        accept_window(fill(99), 0, '0, 0, 0);
        wait_result("post_rst_reload", fill(99), 0);

        // Randomized kernels, sums and windows
        for (int it = 0; it < 25; it++) begin
            k  = $urandom_range(0, 7);
            kr = rnd_arr(($urandom_range(0, 1) == 1) ? 255 : 15);
            case ($urandom_range(0, 9))
                0:       s = 0;
                1:       s = 32'h0100_0000 + 32'($urandom_range(0, 1000));
                2:       s = 32'($urandom_range(1, 50));
                default: s = 32'(wsum(kr, k));
            endcase
            load_kernel(kr, s, k);
            w1 = rnd_arr(255);
            accept_window(w1, 0, '0, 0, 0);
            wait_result("rand", w1, $urandom_range(0, 3));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
